// File: rtl/mult_pkg.sv
// Shared definitions for the bit-serial shift-add multiplier.
//   state_t   : controller states (IDLE, ADD, SHIFT, DONE)
//   DEFAULT_W : default operand width
//   lat()     : cycles from accepted start to the DONE state, w*(w+1)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_W = 8;

  // One ADD cycle per bit plus one SHIFT cycle, for every row.
  function automatic int lat(input int w);
    return w * (w + 1);
  endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell, time-shared by the serial multiplier.
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-add multiplier controller. A single full-adder cell is
// stepped across every bit of every partial-product row; the row carry is
// kept in a flop until the SHIFT cycle folds it into the accumulator.
//
// Handshake: start is sampled only in IDLE or DONE. An accepted start
// latches a_in/b_in and raises busy from the next cycle for W*(W+1)
// cycles; done then pulses for one cycle with product valid. start while
// busy is ignored, and product holds until the next done.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   start     : request a multiply
//   a_in/b_in : multiplicand / multiplier (W bits, unsigned)
//   busy      : high in ADD or SHIFT
//   done      : one-cycle pulse, product valid
//   product   : 2W-bit unsigned product
//   dbg_state : current controller state (observation only)
module serial_mult_ctrl
  import mult_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product,
  output logic [1:0]       dbg_state
);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;     // multiplicand
  logic [W-1:0]     u_q, u_d;     // upper accumulator
  logic [W-1:0]     l_q, l_d;     // multiplier, becomes product low half
  logic             c_q, c_d;     // carry between bit-cycles
  logic [CW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    row_q, row_d;
  logic [2*W-1:0]   prod_q, prod_d;

  logic fa_sum, fa_co;

  // L[0] is constant across a row, so gating A[k] with it selects A or 0.
  fulladder u_fa (
    .a     (u_q[bit_q]),
    .b     (a_q[bit_q] & l_q[0]),
    .c     (c_q),
    .sum   (fa_sum),
    .carry (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      u_q     <= '0;
      l_q     <= '0;
      c_q     <= 1'b0;
      bit_q   <= '0;
      row_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      u_q     <= u_d;
      l_q     <= l_d;
      c_q     <= c_d;
      bit_q   <= bit_d;
      row_q   <= row_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    u_d     = u_q;
    l_d     = l_q;
    c_d     = c_q;
    bit_d   = bit_q;
    row_d   = row_q;
    prod_d  = prod_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          l_d     = b_in;
          u_d     = '0;
          c_d     = 1'b0;
          bit_d   = '0;
          row_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        u_d[bit_q] = fa_sum;
        c_d        = fa_co;
        bit_d      = bit_q + CW'(1);
        if (bit_q == CW'(W - 1)) state_d = SHIFT;
      end

      SHIFT: begin
        // {carry, U, L} >> 1; the carry lands in U's MSB.
        u_d   = {c_q, u_q[W-1:1]};
        l_d   = {u_q[0], l_q[W-1:1]};
        c_d   = 1'b0;
        bit_d = '0;
        row_d = row_q + CW'(1);
        if (row_q == CW'(W - 1)) begin
          state_d = DONE;
          // Register the shifted result so it is visible during DONE.
          prod_d  = {u_d, l_d};
        end else begin
          state_d = ADD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == ADD) || (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign product   = prod_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Testbench for serial_mult_ctrl: one W=4 and one W=8 instance on a
// shared clock, a table of directed multiplies, and hand-written
// sequences for ignored start, back-to-back start and mid-run reset.
module tb_serial_mult_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;
  logic [1:0]  st4;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic [1:0]  st8;

  serial_mult_ctrl #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .product(prod4), .dbg_state(st4)
  );

  serial_mult_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .product(prod8), .dbg_state(st8)
  );

  // ---------------- scoreboard counters ----------------
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic cur_busy(input bit use8);
    return use8 ? busy8 : busy4;
  endfunction

  function automatic logic cur_done(input bit use8);
    return use8 ? done8 : done4;
  endfunction

  function automatic logic [15:0] cur_prod(input bit use8);
    return use8 ? prod8 : {8'd0, prod4};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_start(input bit use8, input logic [7:0] a, input logic [7:0] b);
    if (use8) begin
      start8 = 1'b1; a8 = a; b8 = b;
    end else begin
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0];
    end
  endtask

  task automatic clear_start();
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Start edge T, then sample #1 after it: busy must already be high.
  task automatic start_op(input bit use8, input logic [7:0] a, input logic [7:0] b,
                          input string name);
    @(negedge clk);
    drive_start(use8, a, b);
    @(posedge clk);
    #1;
    clear_start();
    check({name, " busy_at_start"}, 32'(cur_busy(use8)), 32'd1);
  endtask

  // Counts edges after the start edge until done; busy must stay high
  // until then. poke_at >= 0 pulses an intrusive start (a=7) mid-run.
  task automatic wait_done(input bit use8, input int exp_lat, input logic [15:0] exp_p,
                           input string name, input int poke_at);
    int  n;
    bit  seen;
    bit  busy_ok;
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < exp_lat + 10) begin
      @(posedge clk);
      #1;
      n++;
      if (n == poke_at) drive_start(use8, 8'd7, 8'd11);
      else if (n == poke_at + 1) clear_start();
      if (cur_done(use8)) seen = 1'b1;
      else if (!cur_busy(use8)) busy_ok = 1'b0;
    end
    clear_start();
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " busy_through_run"}, 32'(busy_ok), 32'd1);
    check({name, " busy_low_in_done"}, 32'(cur_busy(use8)), 32'd0);
    check({name, " product"}, 32'(cur_prod(use8)), 32'(exp_p));
  endtask

  task automatic run_op(input bit use8, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [15:0] exp_p, input string name);
    start_op(use8, a, b, name);
    wait_done(use8, exp_lat, exp_p, name, -1);
    @(posedge clk);
    #1;
    check({name, " done_one_cycle"}, 32'(cur_done(use8)), 32'd0);
    check({name, " product_held"}, 32'(cur_prod(use8)), 32'(exp_p));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          use8;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  idle_cnt;
    bit  spurious;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  20, 16'd143,   "w4_13x11"};
    vecs[1] = '{1'b0, 8'd15,  8'd15,  20, 16'd225,   "w4_15x15"};
    vecs[2] = '{1'b0, 8'd0,   8'd9,   20, 16'd0,     "w4_0x9"};
    vecs[3] = '{1'b0, 8'd1,   8'd1,   20, 16'd1,     "w4_1x1"};
    vecs[4] = '{1'b0, 8'd9,   8'd6,   20, 16'd54,    "w4_9x6"};
    vecs[5] = '{1'b1, 8'd255, 8'd255, 72, 16'd65025, "w8_255x255"};
    vecs[6] = '{1'b1, 8'd1,   8'd200, 72, 16'd200,   "w8_1x200"};
    vecs[7] = '{1'b1, 8'd170, 8'd85,  72, 16'd14450, "w8_170x85"};

    rst_n = 1'b0;
    clear_start();
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy4", 32'(busy4), 32'd0);
    check("rst done4", 32'(done4), 32'd0);
    check("rst prod4", 32'(prod4), 32'd0);
    check("rst state4", 32'(st4), 32'd0);
    check("rst busy8", 32'(busy8), 32'd0);
    check("rst done8", 32'(done8), 32'd0);
    check("rst prod8", 32'(prod8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven multiplies
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].use8, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].exp, vecs[i].name);
    end

    // Start re-pulsed with a different a_in while busy: ignored
    start_op(1'b0, 8'd13, 8'd11, "ignore");
    wait_done(1'b0, 20, 16'd143, "ignore", 5);

    // start high during DONE: back-to-back acceptance
    @(posedge clk);
    #1;
    start_op(1'b0, 8'd13, 8'd11, "b2b_first");
    wait_done(1'b0, 20, 16'd143, "b2b_first", -1);
    drive_start(1'b0, 8'd3, 8'd5);
    @(posedge clk);
    #1;
    clear_start();
    check("b2b busy_next", 32'(busy4), 32'd1);
    check("b2b done_next", 32'(done4), 32'd0);
    check("b2b product_kept", 32'(prod4), 32'd143);
    wait_done(1'b0, 20, 16'd15, "b2b_second", -1);

    // Reset in the middle of a run
    @(posedge clk);
    #1;
    start_op(1'b0, 8'd13, 8'd11, "midrst");
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst busy", 32'(busy4), 32'd0);
    check("midrst done", 32'(done4), 32'd0);
    check("midrst product", 32'(prod4), 32'd0);
    rst_n = 1'b1;
    spurious = 1'b0;
    idle_cnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      idle_cnt++;
      if (done4 || busy4) spurious = 1'b1;
    end
    check("midrst no_done", 32'(spurious), 32'd0);
    run_op(1'b0, 8'd6, 8'd7, 20, 16'd42, "after_rst_6x7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
